// File: rtl/ldpc_pkg.sv
// Shared constants and FSM state type for the rate-0.5, 1024-bit LDPC decoder
// early-termination logic.
package ldpc_pkg;

    localparam int N            = 1024;
    localparam int M            = 512;
    localparam int CHUNK_DEF    = 64;
    localparam int MAX_ITER_DEF = 50;
    localparam int ITW          = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYN,
        SCAN,
        DECIDE
    } term_state_e;

endpackage

// File: rtl/syn_term_ctrl_if.sv
// Sequencer <-> early-termination controller signal bundle.
// The master side is the decoder sequencer; the slave side is syn_term_ctrl.
interface syn_term_ctrl_if #(
    parameter int M   = ldpc_pkg::M,
    parameter int ITW = ldpc_pkg::ITW
);
    localparam int CW = $clog2(M + 1);

    logic           start;
    logic           syn_valid;
    logic [M-1:0]   syn_bits;
    logic           iter_next;
    logic           done;
    logic           success;
    logic [ITW-1:0] iter_count;
    logic           busy;
    logic [CW-1:0]  unsat_cnt;

    modport master (
        output start, syn_valid, syn_bits,
        input  iter_next, done, success, iter_count, busy, unsat_cnt
    );

    modport slave (
        input  start, syn_valid, syn_bits,
        output iter_next, done, success, iter_count, busy, unsat_cnt
    );

endinterface

// File: rtl/syn_chunk_reduce.sv
// Reduces one CHUNK-bit syndrome slice to an "any unsatisfied" bit.
// Build macro SYN_WEIGHT_EN adds the slice popcount output.
module syn_chunk_reduce #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0]             slice_i,
`ifdef SYN_WEIGHT_EN
    output logic [$clog2(CHUNK+1)-1:0]   popcnt_o,
`endif
    output logic                         any_o
);
    assign any_o = |slice_i;

`ifdef SYN_WEIGHT_EN
    localparam int PCW = $clog2(CHUNK + 1);

    // NOTE: blocking assignments belong in always_comb; the running sum relies on them.
    always_comb begin
        popcnt_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            popcnt_o = popcnt_o + PCW'(slice_i[i]);
        end
    end
`endif

endmodule

// File: rtl/syn_term_ctrl.sv
// LDPC early-termination controller: captures syndromes, OR-reduces them CHUNK bits
// per cycle, then signals success, failure or another iteration. Macro: SYN_WEIGHT_EN.
module syn_term_ctrl #(
    parameter int M        = ldpc_pkg::M,
    parameter int CHUNK    = ldpc_pkg::CHUNK_DEF,
    parameter int MAX_ITER = ldpc_pkg::MAX_ITER_DEF,
    parameter int ITW      = ldpc_pkg::ITW
) (
    input  logic           clk,
    input  logic           rst,
    syn_term_ctrl_if.slave bus
);
    localparam int NCHUNK = M / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = $clog2(M + 1);

    if (M % CHUNK != 0) begin : g_chunk_check
        $error("syn_term_ctrl: M must be a multiple of CHUNK");
    end
    if (MAX_ITER < 1 || MAX_ITER > 255 || MAX_ITER > (1 << ITW) - 1) begin : g_iter_check
        $error("syn_term_ctrl: MAX_ITER out of range for ITW");
    end

    ldpc_pkg::term_state_e state_q, state_d;

    logic [M-1:0]     shadow_q, shadow_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             any_unsat_q, any_unsat_d;
    logic [ITW-1:0]   iter_count_q, iter_count_d;
    logic             done_q, done_d;
    logic             iter_next_q, iter_next_d;
    logic             success_q, success_d;

    logic [CHUNK-1:0] chunk_slice;
    logic             chunk_any;
    logic             last_chunk;
    logic [ITW-1:0]   iter_inc;

    assign chunk_slice = shadow_q[idx_q * CHUNK +: CHUNK];
    assign last_chunk  = (idx_q == IDXW'(NCHUNK - 1));
    assign iter_inc    = iter_count_q + ITW'(1);

`ifdef SYN_WEIGHT_EN
    logic [$clog2(CHUNK+1)-1:0] chunk_pop;
    logic [CW-1:0]              unsat_acc_q, unsat_acc_d;
    logic [CW-1:0]              unsat_cnt_q, unsat_cnt_d;

    syn_chunk_reduce #(.CHUNK(CHUNK)) u_reduce (
        .slice_i  (chunk_slice),
        .popcnt_o (chunk_pop),
        .any_o    (chunk_any)
    );
`else
    syn_chunk_reduce #(.CHUNK(CHUNK)) u_reduce (
        .slice_i (chunk_slice),
        .any_o   (chunk_any)
    );
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ldpc_pkg::IDLE;
        else     state_q <= state_d;
    end

    // start restarts the frame from any state, overriding syn_valid and the decision.
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = ldpc_pkg::WAIT_SYN;
        end else begin
            case (state_q)
                ldpc_pkg::WAIT_SYN: if (bus.syn_valid) state_d = ldpc_pkg::SCAN;
                ldpc_pkg::SCAN:     if (last_chunk)    state_d = ldpc_pkg::DECIDE;
                ldpc_pkg::DECIDE: begin
                    if (!any_unsat_q || iter_inc == ITW'(MAX_ITER)) state_d = ldpc_pkg::IDLE;
                    else                                             state_d = ldpc_pkg::WAIT_SYN;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        any_unsat_d  = any_unsat_q;
        iter_count_d = iter_count_q;
        success_d    = success_q;
        done_d       = 1'b0;
        iter_next_d  = 1'b0;
        if (bus.start) begin
            iter_count_d = '0;
            success_d    = 1'b0;
        end else begin
            case (state_q)
                ldpc_pkg::WAIT_SYN: begin
                    if (bus.syn_valid) begin
                        shadow_d    = bus.syn_bits;
                        idx_d       = '0;
                        any_unsat_d = 1'b0;
                    end
                end
                ldpc_pkg::SCAN: begin
                    any_unsat_d = any_unsat_q | chunk_any;
                    idx_d       = idx_q + IDXW'(1);
                end
                ldpc_pkg::DECIDE: begin
                    iter_count_d = iter_inc;
                    if (!any_unsat_q) begin
                        done_d    = 1'b1;
                        success_d = 1'b1;
                    end else if (iter_inc == ITW'(MAX_ITER)) begin
                        done_d    = 1'b1;
                        success_d = 1'b0;
                    end else begin
                        iter_next_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the wide shadow register is reset as well, so nothing stale survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            idx_q        <= '0;
            any_unsat_q  <= 1'b0;
            iter_count_q <= '0;
            done_q       <= 1'b0;
            iter_next_q  <= 1'b0;
            success_q    <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            any_unsat_q  <= any_unsat_d;
            iter_count_q <= iter_count_d;
            done_q       <= done_d;
            iter_next_q  <= iter_next_d;
            success_q    <= success_d;
        end
    end

`ifdef SYN_WEIGHT_EN
    always_comb begin
        unsat_acc_d = unsat_acc_q;
        unsat_cnt_d = unsat_cnt_q;
        if (bus.start) begin
            unsat_cnt_d = '0;
        end else begin
            case (state_q)
                ldpc_pkg::WAIT_SYN: if (bus.syn_valid) unsat_acc_d = '0;
                ldpc_pkg::SCAN:     unsat_acc_d = unsat_acc_q + CW'(chunk_pop);
                ldpc_pkg::DECIDE:   unsat_cnt_d = unsat_acc_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            unsat_acc_q <= '0;
            unsat_cnt_q <= '0;
        end else begin
            unsat_acc_q <= unsat_acc_d;
            unsat_cnt_q <= unsat_cnt_d;
        end
    end

    assign bus.unsat_cnt = unsat_cnt_q;
`else
    assign bus.unsat_cnt = '0;
`endif

    assign bus.iter_next  = iter_next_q;
    assign bus.done       = done_q;
    assign bus.success    = success_q;
    assign bus.iter_count = iter_count_q;
    assign bus.busy       = (state_q != ldpc_pkg::IDLE);

endmodule

// File: tb/tb_syn_term_ctrl.sv
// Self-checking bench for syn_term_ctrl: a 512/64 instance with MAX_ITER=5 and a
// 128/128 instance with MAX_ITER=1, both checked against a frame-level model.
module tb_syn_term_ctrl;
    import ldpc_pkg::*;

    localparam int M_A     = 512;
    localparam int CHUNK_A = 64;
    localparam int MAXI_A  = 5;
    localparam int LAT_A   = M_A / CHUNK_A + 1;
    localparam int M_B     = 128;
    localparam int CHUNK_B = 128;
    localparam int MAXI_B  = 1;
    localparam int LAT_B   = 2;
    localparam int BUDGET  = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   m_iter_a = 0;
    int   m_iter_b = 0;

    always #5 clk = ~clk;

    syn_term_ctrl_if #(.M(M_A), .ITW(ITW)) bus_a ();
    syn_term_ctrl_if #(.M(M_B), .ITW(ITW)) bus_b ();

    syn_term_ctrl #(.M(M_A), .CHUNK(CHUNK_A), .MAX_ITER(MAXI_A), .ITW(ITW)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    syn_term_ctrl #(.M(M_B), .CHUNK(CHUNK_B), .MAX_ITER(MAXI_B), .ITW(ITW)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Reported weight of a failing syndrome: its popcount only in the weighted build.
    function automatic int expect_unsat(input int ones);
`ifdef SYN_WEIGHT_EN
        return ones;
`else
        return (ones >= 0) ? 0 : 0;
`endif
    endfunction

    function automatic logic [M_A-1:0] rand_syn_a(input int zero_pct);
        logic [M_A-1:0] b;
        b = '0;
        if ($urandom_range(99) >= zero_pct) begin
            int k;
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) b[$urandom_range(M_A - 1)] = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [M_A-1:0] rand_noise_a();
        logic [M_A-1:0] b;
        for (int i = 0; i < M_A / 32; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        m_iter_a = 0;
    endtask

    task automatic start_b();
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        m_iter_b = 0;
    endtask

    // Counts cycles in which instance A shows any decision pulse.
    task automatic watch_quiet_a(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            tick();
            if (bus_a.done || bus_a.iter_next) hits++;
        end
    endtask

    // One evaluation on instance A; inject_at >= 0 fires a stray syn_valid mid-scan.
    task automatic eval_a(input logic [M_A-1:0] bits, input int inject_at, input string name);
        int n;
        bit exp_succ, exp_done;
        int exp_unsat;
        m_iter_a++;
        exp_succ  = (bits == '0);
        exp_done  = exp_succ || (m_iter_a == MAXI_A);
        exp_unsat = expect_unsat($countones(bits));

        bus_a.syn_bits  = bits;
        bus_a.syn_valid = 1'b1;
        tick();
        bus_a.syn_valid = 1'b0;
        bus_a.syn_bits  = rand_noise_a();
        n = 0;
        while (!(bus_a.done || bus_a.iter_next) && n < BUDGET) begin
            if (n == inject_at) bus_a.syn_valid = 1'b1;
            tick();
            bus_a.syn_valid = 1'b0;
            n++;
        end

        total++;
        if (n !== LAT_A) begin
            bad++; $display("FAIL %s latency: got %0d expected %0d", name, n, LAT_A);
        end
        total++;
        if (bus_a.done !== exp_done) begin
            bad++; $display("FAIL %s done: got %b expected %b", name, bus_a.done, exp_done);
        end
        total++;
        if (bus_a.iter_next !== !exp_done) begin
            bad++; $display("FAIL %s iter_next: got %b expected %b", name, bus_a.iter_next, !exp_done);
        end
        if (exp_done) begin
            total++;
            if (bus_a.success !== exp_succ) begin
                bad++; $display("FAIL %s success: got %b expected %b", name, bus_a.success, exp_succ);
            end
        end
        total++;
        if (bus_a.iter_count !== ITW'(m_iter_a)) begin
            bad++; $display("FAIL %s iter_count: got %0d expected %0d", name, bus_a.iter_count, m_iter_a);
        end
        total++;
        if (bus_a.unsat_cnt !== 10'(exp_unsat)) begin
            bad++; $display("FAIL %s unsat_cnt: got %0d expected %0d", name, bus_a.unsat_cnt, exp_unsat);
        end
        total++;
        if (bus_a.busy !== !exp_done) begin
            bad++; $display("FAIL %s busy: got %b expected %b", name, bus_a.busy, !exp_done);
        end
        tick();
        total++;
        if (bus_a.done !== 1'b0 || bus_a.iter_next !== 1'b0) begin
            bad++; $display("FAIL %s pulse_width: got done=%b iter_next=%b expected 0", name, bus_a.done, bus_a.iter_next);
        end
        if (exp_done) begin
            total++;
            if (bus_a.success !== exp_succ) begin
                bad++; $display("FAIL %s success_hold: got %b expected %b", name, bus_a.success, exp_succ);
            end
        end
    endtask

    task automatic eval_b(input logic [M_B-1:0] bits, input string name);
        int n;
        bit exp_succ, exp_done;
        m_iter_b++;
        exp_succ = (bits == '0);
        exp_done = exp_succ || (m_iter_b == MAXI_B);
        bus_b.syn_bits  = bits;
        bus_b.syn_valid = 1'b1;
        tick();
        bus_b.syn_valid = 1'b0;
        bus_b.syn_bits  = ~bits;
        n = 0;
        while (!(bus_b.done || bus_b.iter_next) && n < BUDGET) begin
            tick();
            n++;
        end
        total++;
        if (n !== LAT_B) begin
            bad++; $display("FAIL %s latency: got %0d expected %0d", name, n, LAT_B);
        end
        total++;
        if (bus_b.done !== exp_done || bus_b.iter_next !== !exp_done) begin
            bad++; $display("FAIL %s kind: got done=%b iter_next=%b expected done=%b", name, bus_b.done, bus_b.iter_next, exp_done);
        end
        total++;
        if (bus_b.success !== exp_succ) begin
            bad++; $display("FAIL %s success: got %b expected %b", name, bus_b.success, exp_succ);
        end
        total++;
        if (bus_b.iter_count !== ITW'(m_iter_b) || bus_b.unsat_cnt !== 8'(expect_unsat($countones(bits)))) begin
            bad++; $display("FAIL %s count: got iter=%0d unsat=%0d expected iter=%0d unsat=%0d", name,
                            bus_b.iter_count, bus_b.unsat_cnt, m_iter_b, expect_unsat($countones(bits)));
        end
        tick();
        total++;
        if (bus_b.done !== 1'b0 || bus_b.iter_next !== 1'b0 || bus_b.busy !== 1'b0) begin
            bad++; $display("FAIL %s after_done: got done=%b iter_next=%b busy=%b expected 0", name, bus_b.done, bus_b.iter_next, bus_b.busy);
        end
    endtask

    task automatic test_reset();
        int hits;
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({bus_a.iter_next, bus_a.done, bus_a.success, bus_a.busy} !== 4'b0 ||
            bus_a.iter_count !== '0 || bus_a.unsat_cnt !== '0) begin
            bad++; $display("FAIL reset_a: got flags=%b iter=%0d unsat=%0d expected 0",
                            {bus_a.iter_next, bus_a.done, bus_a.success, bus_a.busy}, bus_a.iter_count, bus_a.unsat_cnt);
        end
        total++;
        if ({bus_b.iter_next, bus_b.done, bus_b.success, bus_b.busy} !== 4'b0 ||
            bus_b.iter_count !== '0 || bus_b.unsat_cnt !== '0) begin
            bad++; $display("FAIL reset_b: got flags=%b iter=%0d expected 0",
                            {bus_b.iter_next, bus_b.done, bus_b.success, bus_b.busy}, bus_b.iter_count);
        end
        rst = 1'b0;
        bus_a.syn_bits  = rand_noise_a();
        bus_a.syn_valid = 1'b1;
        tick();
        bus_a.syn_valid = 1'b0;
        hits = 0;
        repeat (LAT_A + 4) begin
            tick();
            if (bus_a.done || bus_a.iter_next || bus_a.busy) hits++;
        end
        total++;
        if (hits !== 0) begin
            bad++; $display("FAIL syn_valid_in_idle: got %0d active cycles expected 0", hits);
        end

        start_a();
        bus_a.syn_bits  = rand_noise_a();
        bus_a.syn_valid = 1'b1;
        tick();
        bus_a.syn_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus_a.busy !== 1'b0 || bus_a.iter_count !== '0 || bus_a.done !== 1'b0) begin
            bad++; $display("FAIL reset_mid_scan: got busy=%b iter=%0d done=%b expected 0", bus_a.busy, bus_a.iter_count, bus_a.done);
        end
        watch_quiet_a(LAT_A + 4, hits);
        total++;
        if (hits !== 0) begin
            bad++; $display("FAIL reset_no_pending_pulse: got %0d pulses expected 0", hits);
        end
    endtask

    task automatic test_immediate_success();
        start_a();
        total++;
        if (bus_a.busy !== 1'b1 || bus_a.iter_count !== '0) begin
            bad++; $display("FAIL start_state: got busy=%b iter=%0d expected busy=1 iter=0", bus_a.busy, bus_a.iter_count);
        end
        eval_a('0, -1, "immediate_success");
    endtask

    task automatic test_convergence();
        logic [M_A-1:0] b;
        b = '0;
        b[M_A-1] = 1'b1;
        start_a();
        for (int i = 0; i < 3; i++) eval_a(b, -1, $sformatf("converge_fail%0d", i));
        eval_a('0, -1, "converge_success");
    endtask

    task automatic test_failure();
        logic [M_A-1:0] b;
        b = '0;
        b[3:0] = 4'hF;
        start_a();
        for (int i = 0; i < MAXI_A; i++) eval_a(b, -1, $sformatf("limit_iter%0d", i + 1));
    endtask

    task automatic test_abort();
        int hits;
        start_a();
        bus_a.syn_bits  = rand_syn_a(0);
        bus_a.syn_valid = 1'b1;
        tick();
        bus_a.syn_valid = 1'b0;
        repeat (2) tick();
        start_a();
        watch_quiet_a(LAT_A + 4, hits);
        total++;
        if (hits !== 0) begin
            bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", hits);
        end
        total++;
        if (bus_a.iter_count !== '0 || bus_a.unsat_cnt !== '0 || bus_a.busy !== 1'b1) begin
            bad++; $display("FAIL abort_counts: got iter=%0d unsat=%0d busy=%b expected 0/0/1", bus_a.iter_count, bus_a.unsat_cnt, bus_a.busy);
        end
        total++;
        if (u_dut_a.state_q !== WAIT_SYN) begin
            bad++; $display("FAIL abort_state: got %0d expected %0d", u_dut_a.state_q, WAIT_SYN);
        end
        eval_a('0, -1, "abort_then_success");

        // start landing on the decision cycle overrides the outcome
        start_a();
        bus_a.syn_bits  = rand_syn_a(0);
        bus_a.syn_valid = 1'b1;
        tick();
        bus_a.syn_valid = 1'b0;
        repeat (LAT_A - 1) tick();
        start_a();
        total++;
        if (bus_a.done !== 1'b0 || bus_a.iter_next !== 1'b0 || bus_a.iter_count !== '0) begin
            bad++; $display("FAIL start_over_decide: got done=%b iter_next=%b iter=%0d expected 0", bus_a.done, bus_a.iter_next, bus_a.iter_count);
        end
        watch_quiet_a(4, hits);
        total++;
        if (hits !== 0 || u_dut_a.state_q !== WAIT_SYN) begin
            bad++; $display("FAIL start_over_decide_state: got pulses=%0d state=%0d expected 0/%0d", hits, u_dut_a.state_q, WAIT_SYN);
        end
        eval_a('0, -1, "decide_abort_then_success");
    endtask

    task automatic test_edges();
        int hits;
        start_a();
        bus_a.syn_bits  = rand_syn_a(0);
        bus_a.syn_valid = 1'b1;
        bus_a.start     = 1'b1;
        tick();
        bus_a.syn_valid = 1'b0;
        bus_a.start     = 1'b0;
        m_iter_a = 0;
        watch_quiet_a(LAT_A + 4, hits);
        total++;
        if (hits !== 0 || bus_a.iter_count !== '0 || u_dut_a.state_q !== WAIT_SYN) begin
            bad++; $display("FAIL start_with_syn_valid: got pulses=%0d iter=%0d state=%0d expected 0/0/%0d",
                            hits, bus_a.iter_count, u_dut_a.state_q, WAIT_SYN);
        end
        eval_a(rand_syn_a(0), 2, "stray_syn_valid_fail");
        eval_a('0, 3, "stray_syn_valid_success");
    endtask

    task automatic test_small();
        logic [M_B-1:0] b;
        start_b();
        b = '0;
        b[$urandom_range(M_B - 1)] = 1'b1;
        eval_b(b, "small_fail_at_limit");
        start_b();
        eval_b('0, "small_success");
        for (int i = 0; i < 6; i++) begin
            start_b();
            b = '0;
            if ($urandom_range(1) == 1) b[$urandom_range(M_B - 1)] = 1'b1;
            eval_b(b, $sformatf("small_rand%0d", i));
        end
    endtask

    task automatic test_random();
        logic [M_A-1:0] b;
        bit over;
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 3)) tick();
            start_a();
            over = 1'b0;
            while (!over) begin
                repeat ($urandom_range(0, 3)) tick();
                b = rand_syn_a(30);
                eval_a(b, ($urandom_range(3) == 0) ? int'($urandom_range(0, LAT_A - 3)) : -1,
                       $sformatf("rand_f%0d_i%0d", f, m_iter_a + 1));
                over = (b == '0) || (m_iter_a == MAXI_A);
            end
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.syn_valid = 1'b0; bus_a.syn_bits = '0;
        bus_b.start = 1'b0; bus_b.syn_valid = 1'b0; bus_b.syn_bits = '0;
        test_reset();
        test_immediate_success();
        test_convergence();
        test_failure();
        test_abort();
        test_edges();
        test_small();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
